// File: rtl/alu_dispatch.sv
// Streaming valid/ready front-end for SimpleAlu: registers operands, tracks the
// fixed ALU latency and returns results in issue order through a credit-guarded FIFO.
module alu_dispatch #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a,
  input  logic [DATA_WIDTH-1:0] s_b,
  input  logic [2:0]            s_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_x,
  input  logic                  alu_z,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_x,
  output logic                  m_z,
  output logic                  m_err
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NS = ALU_LATENCY + 1;

  logic                  alive;
  logic [NS-1:0]         trk_v;
  logic [NS-1:0]         trk_e;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         inflight;
  logic [DATA_WIDTH-1:0] mem_x [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_z;
  logic [FIFO_DEPTH-1:0] mem_e;
  logic                  accept;
  logic                  illegal;
  logic                  push;
  logic                  pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      inflight = inflight + CW'(trk_v[i]);
    end
  end

  // Every tracked op already owns a FIFO slot, so a capture can never overflow.
  assign s_ready = alive && (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;
  assign illegal = (s_op == 3'd7);
  assign push    = trk_v[NS-1];
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_x     = mem_x[rd_ptr];
  assign m_z     = mem_z[rd_ptr];
  assign m_err   = mem_e[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alive      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      trk_v      <= '0;
      trk_e      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      mem_z      <= '0;
      mem_e      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_x[i] <= '0;
      end
    end else begin
      alive <= 1'b1;
      if (accept) begin
        alu_a  <= s_a;
        alu_b  <= s_b;
        alu_op <= illegal ? 3'd0 : s_op;
      end
      trk_v <= (trk_v << 1) | NS'(accept);
      trk_e <= (trk_e << 1) | NS'(accept && illegal);
      if (push) begin
        mem_x[wr_ptr] <= trk_e[NS-1] ? '0 : alu_x;
        mem_z[wr_ptr] <= trk_e[NS-1] ? 1'b0 : alu_z;
        mem_e[wr_ptr] <= trk_e[NS-1];
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end
endmodule
